serial_mux_adder_ctrl: RTL and testbench
========================================

SERIAL_MUX_ADDER_CTRL -- requirements
Module: serial_mux_adder_ctrl

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits; legal range 1..32.
REQ-002 Port clk, input, 1 bit: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin an addition; single-cycle pulse or level.
REQ-005 Port a, input, WIDTH bits: operand A; sampled only when a start is accepted.
REQ-006 Port b, input, WIDTH bits: operand B; sampled only when a start is accepted.
REQ-007 Port cin, input, 1 bit: carry-in; sampled only when a start is accepted.
REQ-008 Port busy, output, 1 bit: registered; high while an addition is in progress.
REQ-009 Port done, output, 1 bit: registered; one-cycle pulse when the result is valid.
REQ-010 Port sum, output, WIDTH bits: registered result, held until the next completion.
REQ-011 Port cout, output, 1 bit: registered carry-out, held until the next completion.

Function
REQ-012 The block SHALL contain one full-adder cell built as two 8:1 truth-table muxes.
- Both muxes select on {a_bit, b_bit, c_reg}, with a_bit as the MSB.
- Sum table (select 0..7) SHALL be 0,1,1,0,1,0,0,1.
- Carry table (select 0..7) SHALL be 0,0,0,1,0,1,1,1.
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 IDLE with start=1: the block SHALL load the operand shift registers from a and b.
- Carry register <= cin.
- Bit counter <= 0.
- Next state RUN.
REQ-015 IDLE with start=0: the block SHALL remain in IDLE with all registers unchanged.
REQ-016 In RUN, each cycle SHALL process one bit, LSB first.
- The cell output for the current LSBs and c_reg is computed.
- Sum bit shifts into the MSB of an internal result shift register.
- Operand registers shift right by one.
- c_reg <= cell carry.
- Counter increments.
REQ-017 After the RUN cycle with counter = WIDTH-1, the next state SHALL be DONE.
- sum <= completed internal shift register value.
- cout <= final cell carry.
REQ-018 DONE SHALL last exactly one cycle.
- With start=0 in DONE: next state IDLE.
- With start=1 in DONE: the start is accepted exactly as in IDLE, and next state is RUN.
REQ-019 busy SHALL equal 1 exactly while state is RUN.
REQ-020 done SHALL equal 1 exactly while state is DONE.
REQ-021 Latency: if start is accepted at edge T, done SHALL be high in the cycle after edge T+WIDTH.
- busy is high for exactly WIDTH cycles.
REQ-022 start SHALL be ignored while in RUN, with no effect on the operation in progress.
REQ-023 Changes on a, b or cin after acceptance SHALL NOT affect the result in progress.
REQ-024 sum and cout SHALL keep their previous values during RUN and update only on entry to DONE.
REQ-025 {cout, sum} SHALL equal a + b + cin modulo 2^(WIDTH+1).
REQ-026 The counter SHALL be $clog2(WIDTH+1) bits wide and SHALL NOT wrap during an operation.

Reset
REQ-027 When rst=1 at a clock edge, the block SHALL enter IDLE and clear all state.
- Cleared: operand registers, result shift register, c_reg, counter.
- Outputs: busy=0, done=0, sum=0, cout=0.
REQ-028 rst SHALL take priority over start and over any in-progress operation.
- Reset mid-RUN aborts the operation with no done pulse.
REQ-029 The first cycle after rst deasserts SHALL accept a start.

Verification
REQ-030 Reset: assert rst 2 cycles -> busy=0, done=0, sum=0, cout=0; start=1 in the first cycle after release is accepted.
REQ-031 WIDTH=8, a=0x0F, b=0x01, cin=0, start pulse at edge T:
- busy is high for the cycles after edges T..T+7 (8 cycles).
- done pulses once in the cycle after edge T+8.
- sum=0x10, cout=0.
REQ-032 WIDTH=8 boundary cases:
- 0xFF+0x01, cin=0 -> sum=0x00, cout=1.
- 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
- 0x00+0x00, cin=0 -> sum=0x00, cout=0.
REQ-033 Stability during RUN: hold start=1 and change a/b/cin to random values on every RUN cycle.
- The result matches the values sampled at acceptance.
- Exactly one done pulse per accepted start.
- Back-to-back operations via start in DONE complete with no idle gap.
REQ-034 Reset mid-operation: assert rst in the 4th RUN cycle.
- The next cycle shows busy=0 and sum=0.
- No done pulse occurs.
- A new start then completes correctly (0x5A+0xA5, cin=1 -> sum=0x00, cout=1).
REQ-035 Cell truth table with WIDTH=1: drive all 8 combinations of {a, b, cin} -> {cout, sum} SHALL equal a+b+cin in each case, with done one cycle after busy.

Source files
------------

// File: rtl/serial_mux_adder_ctrl.sv
// rtl/serial_mux_adder_ctrl.sv - bit-serial adder built from a mux-based full-adder cell
//
// Ports:
//   clk   - clock, all state updates on the rising edge
//   rst   - synchronous active-high reset
//   start - begin an addition (accepted in IDLE or DONE)
//   a, b  - WIDTH-bit operands, sampled on acceptance
//   cin   - carry-in, sampled on acceptance
//   busy  - high while bits are being processed
//   done  - one-cycle pulse when sum/cout are fresh
//   sum   - result, held until the next completion
//   cout  - carry-out, held until the next completion

module serial_mux_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  // Full-adder truth tables indexed by {a_bit, b_bit, carry}.
  localparam logic [7:0] SUM_TBL   = 8'b1001_0110;
  localparam logic [7:0] CARRY_TBL = 8'b1110_1000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             c_reg;
  logic [CW-1:0]    cnt;
  logic [2:0]       sel;
  logic             s_bit, c_bit;
  logic             last, accept;

  always_comb begin
    sel    = {a_sh[0], b_sh[0], c_reg};
    s_bit  = SUM_TBL[sel];
    c_bit  = CARRY_TBL[sel];
    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    res_nxt = WIDTH'({s_bit, res_sh} >> 1);
    last   = (cnt == CW'(WIDTH - 1));
    accept = start && ((state == IDLE) || (state == DONE));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done come straight from flops, decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == RUN);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      c_reg  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      c_reg <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nxt;
      c_reg  <= c_bit;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum  <= res_nxt;
        cout <= c_bit;
      end
    end
  end

endmodule

// File: tb/tb_serial_mux_adder_ctrl.sv
// tb/tb_serial_mux_adder_ctrl.sv - scoreboard bench for serial_mux_adder_ctrl (WIDTH 8 and 1)

module tb_serial_mux_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst8, start8, cin8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;
  // WIDTH=1 instance
  logic       rst1, start1, cin1, busy1, done1, cout1;
  logic [0:0] a1, b1, sum1;

  serial_mux_adder_ctrl #(.WIDTH(8)) d8 (
    .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_mux_adder_ctrl #(.WIDTH(1)) d1 (
    .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] q8[$];
  logic [1:0] q1[$];
  logic [8:0] e8;
  logic [1:0] e1;
  int run8 = 0;
  int run1 = 0;

  logic [7:0] xa [3] = '{8'h3C, 8'h80, 8'hC3};
  logic [7:0] xb [3] = '{8'h0F, 8'h80, 8'h11};
  logic       xc [3] = '{1'b1, 1'b0, 1'b0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected result whenever done is seen and check busy run length.
  always @(negedge clk) begin
    if (done8) begin
      check("lat8_busy_cycles", 32'(run8), 32'd8);
      if (q8.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL done8_unexpected: got a done pulse, expected none");
      end else begin
        e8 = q8.pop_front();
        check("sum8", 32'(sum8), 32'(e8[7:0]));
        check("cout8", 32'(cout8), 32'(e8[8]));
      end
      run8 = 0;
    end else if (busy8) run8++;
    else run8 = 0;
  end

  always @(negedge clk) begin
    if (done1) begin
      check("lat1_busy_cycles", 32'(run1), 32'd1);
      if (q1.size() == 0) begin
        n_assert++;
        n_fail++;
        $display("FAIL done1_unexpected: got a done pulse, expected none");
      end else begin
        e1 = q1.pop_front();
        check("sum1", 32'(sum1), 32'(e1[0]));
        check("cout1", 32'(cout1), 32'(e1[1]));
      end
      run1 = 0;
    end else if (busy1) run1++;
    else run1 = 0;
  end

  task automatic wait_done8();
    int n = 0;
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done8) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout8: got no done within 40 cycles, expected done");
    end
  endtask

  task automatic wait_done1();
    int n = 0;
    while (!done1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!done1) begin
      n_assert++;
      n_fail++;
      $display("FAIL timeout1: got no done within 10 cycles, expected done");
    end
  endtask

  task automatic do_op8(input logic [7:0] x, input logic [7:0] y, input logic c);
    @(negedge clk);
    start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
    q8.push_back(9'(x) + 9'(y) + 9'(c));
    @(negedge clk);
    start8 = 1'b0;
    wait_done8();
  endtask

  initial begin
    rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;

    // Reset for two cycles, then start in the first cycle after release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_done", 32'(done8), 32'd0);
    check("rst_sum", 32'(sum8), 32'd0);
    check("rst_cout", 32'(cout8), 32'd0);
    check("rst1_sum", 32'(sum1), 32'd0);
    rst8 = 1'b0; rst1 = 1'b0;
    start8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0;
    q8.push_back(9'h010);
    @(negedge clk);
    check("first_start_accepted", 32'(busy8), 32'd1);
    check("sum_held_in_run", 32'(sum8), 32'd0);
    start8 = 1'b0;
    wait_done8();

    // Boundary cases.
    do_op8(8'hFF, 8'h01, 1'b0);
    do_op8(8'hFF, 8'hFF, 1'b1);
    do_op8(8'h00, 8'h00, 1'b0);

    // Back-to-back with start held and operands scrambled during RUN.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      start8 = 1'b1; a8 = xa[k]; b8 = xb[k]; cin8 = xc[k];
      q8.push_back(9'(xa[k]) + 9'(xb[k]) + 9'(xc[k]));
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        if (i == 0) check("b2b_no_gap_busy", 32'(busy8), 32'd1);
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
      @(negedge clk);
      check("b2b_done", 32'(done8), 32'd1);
    end
    start8 = 1'b0;

    // Reset in the 4th RUN cycle aborts without a done pulse.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
    q8.push_back(9'h046);
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_in_run", 32'(busy8), 32'd1);
    rst8 = 1'b1;
    q8.delete();
    @(negedge clk);
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_sum", 32'(sum8), 32'd0);
    check("midrst_done", 32'(done8), 32'd0);
    rst8 = 1'b0;
    repeat (12) @(negedge clk);
    do_op8(8'h5A, 8'hA5, 1'b1);

    // WIDTH=1: every cell input combination.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      @(negedge clk);
      start1 = 1'b1; a1 = v[2]; b1 = v[1]; cin1 = v[0];
      q1.push_back(2'(v[2]) + 2'(v[1]) + 2'(v[0]));
      @(negedge clk);
      start1 = 1'b0;
      wait_done1();
    end

    repeat (3) @(negedge clk);
    check("q8_drained", 32'(q8.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
